// File: rtl/pe_array_ctrl_if.sv
// Bundle between the layer-level control FSM (master) and the PE-array sequencer (slave).
// out_valid/out_ready: the result is transferred in any cycle where both are 1; valid holds until then.
interface pe_array_ctrl_if #(
    parameter int ADDR_BW = 10,
    parameter int CNT_BW  = 8
);
    logic               start;
    logic [CNT_BW-1:0]  cfg_len;
    logic [CNT_BW-1:0]  cfg_tiles;
    logic [ADDR_BW-1:0] cfg_wet_base;
    logic [ADDR_BW-1:0] cfg_act_base;
    logic [7:0]         cfg_shift;
`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
    logic               out_ready;
`endif
    logic               wet_rd_en;
    logic [ADDR_BW-1:0] wet_rd_addr;
    logic               act_rd_en;
    logic [ADDR_BW-1:0] act_rd_addr;
    logic               pe_mac_enable;
    logic               pe_clear_acc;
    logic [7:0]         pe_res_shift_num;
    logic               out_valid;
    logic               busy;
    logic               done;

    modport master (
`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
        output out_ready,
`endif
        output start, cfg_len, cfg_tiles, cfg_wet_base, cfg_act_base, cfg_shift,
        input  wet_rd_en, wet_rd_addr, act_rd_en, act_rd_addr,
        input  pe_mac_enable, pe_clear_acc, pe_res_shift_num,
        input  out_valid, busy, done
    );

    modport slave (
`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
        input  out_ready,
`endif
        input  start, cfg_len, cfg_tiles, cfg_wet_base, cfg_act_base, cfg_shift,
        output wet_rd_en, wet_rd_addr, act_rd_en, act_rd_addr,
        output pe_mac_enable, pe_clear_acc, pe_res_shift_num,
        output out_valid, busy, done
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// PE-array tile sequencer: clear / accumulate / drain / emit per tile, buffer read addressing.
// Optional macro PE_ARRAY_CTRL_OUT_HANDSHAKE_EN makes EMIT wait for out_ready.
module pe_array_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_BW = 10,
    parameter int CNT_BW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    pe_array_ctrl_if.slave bus,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [CNT_BW-1:0]  len_q;
    logic [CNT_BW-1:0]  tiles_q;
    logic [CNT_BW-1:0]  step_q;
    logic [CNT_BW-1:0]  tile_q;
    logic [ADDR_BW-1:0] wet_base_q;
    logic [ADDR_BW-1:0] act_base_q;
    logic [ADDR_BW-1:0] tile_off_q;
    logic [7:0]         shift_q;
    logic [MEM_LAT:0]   rd_pipe;
    logic               clear_d;

    logic zero_job;
    logic last_step;
    logic drain_done;
    logic last_tile;
    logic emit_ack;
    logic rd_en;
    logic clear_acc;
    logic out_valid;
    logic done;

    assign zero_job   = (len_q == '0) || (tiles_q == '0);
    assign last_step  = (step_q == len_q - 1'b1);
    assign drain_done = (step_q == CNT_BW'(MEM_LAT));
    assign last_tile  = (tile_q == tiles_q - 1'b1);

`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
    assign emit_ack = bus.out_ready;
`else
    assign emit_ack = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        clear_acc = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_nxt = S_CLEAR;
            end
            // An empty job still spends one cycle here so the latched config can be tested.
            S_CLEAR: begin
                if (zero_job) begin
                    state_nxt = S_DONE;
                end else begin
                    clear_acc = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                rd_en = 1'b1;
                if (last_step) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (emit_ack) state_nxt = last_tile ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            tiles_q    <= '0;
            step_q     <= '0;
            tile_q     <= '0;
            wet_base_q <= '0;
            act_base_q <= '0;
            tile_off_q <= '0;
            shift_q    <= '0;
            rd_pipe    <= '0;
            clear_d    <= 1'b0;
        end else begin
            clear_d <= clear_acc;
            // rd_pipe[MEM_LAT] is rd_en from MEM_LAT+1 cycles ago: SRAM latency plus PE input register.
            rd_pipe <= {rd_pipe[MEM_LAT-1:0], rd_en};
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q      <= bus.cfg_len;
                        tiles_q    <= bus.cfg_tiles;
                        wet_base_q <= bus.cfg_wet_base;
                        act_base_q <= bus.cfg_act_base;
                        shift_q    <= bus.cfg_shift;
                        step_q     <= '0;
                        tile_q     <= '0;
                        tile_off_q <= '0;
                    end
                end
                S_RUN: begin
                    step_q <= last_step ? '0 : step_q + 1'b1;
                end
                S_DRAIN: begin
                    step_q <= drain_done ? '0 : step_q + 1'b1;
                end
                S_EMIT: begin
                    if (emit_ack) begin
                        tile_q     <= tile_q + 1'b1;
                        tile_off_q <= tile_off_q + ADDR_BW'(len_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wet_rd_en        = rd_en;
    assign bus.act_rd_en        = rd_en;
    assign bus.wet_rd_addr      = rd_en ? (wet_base_q + tile_off_q + ADDR_BW'(step_q)) : '0;
    assign bus.act_rd_addr      = rd_en ? (act_base_q + ADDR_BW'(step_q)) : '0;
    assign bus.pe_clear_acc     = clear_acc;
    assign bus.pe_mac_enable    = clear_d | rd_pipe[MEM_LAT];
    assign bus.pe_res_shift_num = shift_q;
    assign bus.out_valid        = out_valid;
    assign bus.busy             = (state != S_IDLE);
    assign bus.done             = done;
    assign dbg_state            = state;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: directed plan cases plus random jobs against a cycle-schedule model.
module tb_pe_array_ctrl;
  localparam int MEM_LAT = 1;
  localparam int ADDR_BW = 10;
  localparam int CNT_BW  = 8;
  localparam int MAXC    = 256;
`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  pe_array_ctrl_if #(.ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)) bus();

  pe_array_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] prev_shift = 8'd0;

  // per-cycle expected schedule, index = cycles after the start cycle
  logic               exp_rd    [MAXC];
  logic [ADDR_BW-1:0] exp_wa    [MAXC];
  logic [ADDR_BW-1:0] exp_aa    [MAXC];
  logic               exp_mac   [MAXC];
  logic               exp_clr   [MAXC];
  logic               exp_ov    [MAXC];
  logic               exp_ready [MAXC];
  logic               exp_busy  [MAXC];
  logic               exp_done  [MAXC];
  int                 waits     [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Job timeline: clear, len reads, last accumulate MEM_LAT+1 after the last read,
  // one cycle for the PE output register, then emit (held while out_ready is low).
  task automatic build(input int len, input int tiles, input int wb, input int ab, output int last);
    int c;
    int e;
    for (int i = 0; i < MAXC; i++) begin
      exp_rd[i] = 0; exp_wa[i] = '0; exp_aa[i] = '0; exp_mac[i] = 0; exp_clr[i] = 0;
      exp_ov[i] = 0; exp_ready[i] = 0; exp_busy[i] = 0; exp_done[i] = 0;
    end
    c = 1;
    if (len != 0 && tiles != 0) begin
      for (int t = 0; t < tiles; t++) begin
        exp_clr[c]   = 1;
        exp_mac[c+1] = 1;
        for (int k = 0; k < len; k++) begin
          exp_rd[c+1+k] = 1;
          exp_wa[c+1+k] = ADDR_BW'(wb + t * len + k);
          exp_aa[c+1+k] = ADDR_BW'(ab + k);
          exp_mac[c+1+k+MEM_LAT+1] = 1;
        end
        e = c + len + MEM_LAT + 2;
        for (int j = 0; j <= waits[t]; j++) begin
          exp_ov[e+j]    = 1;
          exp_ready[e+j] = (j == waits[t]);
        end
        c = e + waits[t] + 1;
      end
    end else begin
      c = 2;
    end
    for (int i = 1; i <= c; i++) exp_busy[i] = 1;
    exp_done[c] = 1;
    last = c;
  endtask

  task automatic drive_ready(input int c);
`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
    bus.out_ready = exp_ov[c] ? exp_ready[c] : 1'($urandom_range(0, 1));
`else
    if (c < 0) $display("bad cycle index %0d", c);
`endif
  endtask

  task automatic check_cycle(input int c, input logic [7:0] sh);
    check($sformatf("c%0d wet_rd_en", c), bus.wet_rd_en, exp_rd[c]);
    check($sformatf("c%0d act_rd_en", c), bus.act_rd_en, exp_rd[c]);
    if (exp_rd[c]) begin
      check($sformatf("c%0d wet_rd_addr", c), bus.wet_rd_addr, exp_wa[c]);
      check($sformatf("c%0d act_rd_addr", c), bus.act_rd_addr, exp_aa[c]);
    end
    check($sformatf("c%0d pe_mac_enable", c), bus.pe_mac_enable, exp_mac[c]);
    check($sformatf("c%0d pe_clear_acc", c), bus.pe_clear_acc, exp_clr[c]);
    check($sformatf("c%0d out_valid", c), bus.out_valid, exp_ov[c]);
    check($sformatf("c%0d busy", c), bus.busy, exp_busy[c]);
    check($sformatf("c%0d done", c), bus.done, exp_done[c]);
    check($sformatf("c%0d shift", c), bus.pe_res_shift_num, sh);
  endtask

  task automatic run_job(input int len, input int tiles, input int wb, input int ab,
                         input int sh, input bit interfere);
    int last;
    build(len, tiles, wb, ab, last);
    @(posedge clk); #1;
    bus.start        = 1'b1;
    bus.cfg_len      = CNT_BW'(len);
    bus.cfg_tiles    = CNT_BW'(tiles);
    bus.cfg_wet_base = ADDR_BW'(wb);
    bus.cfg_act_base = ADDR_BW'(ab);
    bus.cfg_shift    = 8'(sh);
    drive_ready(0);
    @(negedge clk);
    check_cycle(0, prev_shift);
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk); #1;
      if (interfere && c <= last) begin
        bus.start        = 1'($urandom_range(0, 1));
        bus.cfg_len      = CNT_BW'($urandom);
        bus.cfg_tiles    = CNT_BW'($urandom);
        bus.cfg_wet_base = ADDR_BW'($urandom);
        bus.cfg_act_base = ADDR_BW'($urandom);
        bus.cfg_shift    = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      drive_ready(c);
      @(negedge clk);
      check_cycle(c, 8'(sh));
    end
    prev_shift = 8'(sh);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wet_rd_en"}, bus.wet_rd_en, 0);
    check({tag, " act_rd_en"}, bus.act_rd_en, 0);
    check({tag, " wet_rd_addr"}, bus.wet_rd_addr, 0);
    check({tag, " act_rd_addr"}, bus.act_rd_addr, 0);
    check({tag, " pe_mac_enable"}, bus.pe_mac_enable, 0);
    check({tag, " pe_clear_acc"}, bus.pe_clear_acc, 0);
    check({tag, " shift"}, bus.pe_res_shift_num, 0);
    check({tag, " out_valid"}, bus.out_valid, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " done"}, bus.done, 0);
  endtask

  task automatic abort_test();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.cfg_len = 8'd6; bus.cfg_tiles = 8'd2;
    bus.cfg_wet_base = 10'h040; bus.cfg_act_base = 10'h080; bus.cfg_shift = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort in_run rd_en", bus.wet_rd_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post_abort%0d done", i), bus.done, 0);
      check($sformatf("post_abort%0d busy", i), bus.busy, 0);
      check($sformatf("post_abort%0d mac", i), bus.pe_mac_enable, 0);
    end
    prev_shift = 8'd0;
  endtask

  task automatic clear_waits();
    for (int i = 0; i < 8; i++) waits[i] = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_tiles = '0;
    bus.cfg_wet_base = '0; bus.cfg_act_base = '0; bus.cfg_shift = '0;
`ifdef PE_ARRAY_CTRL_OUT_HANDSHAKE_EN
    bus.out_ready = 1'b0;
`endif
    clear_waits();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(4, 1, 'h10, 'h20, 2, 1'b0);
    run_job(3, 3, 0, 5, 1, 1'b0);
    run_job(0, 5, 'h33, 'h44, 9, 1'b0);
    run_job(5, 0, 'h33, 'h44, 3, 1'b0);
    run_job(4, 1, 'h3FE, 0, 0, 1'b0);
    run_job(5, 2, 'h100, 'h3FC, 4, 1'b1);
    abort_test();
    run_job(3, 2, 'h7, 'h9, 5, 1'b0);
    if (HS) waits[0] = 5;
    run_job(2, 2, 'h50, 'h60, 6, 1'b0);
    clear_waits();

    for (int n = 0; n < 20; n++) begin
      for (int t = 0; t < 8; t++) waits[t] = HS ? int'($urandom_range(0, 3)) : 0;
      run_job($urandom_range(0, 10), $urandom_range(0, 4), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
